simt_pc_stack: RTL
==================

// Module: simt_pc_stack
// PURPOSE
//  Per-block program counter with SIMT divergence support. Replaces the single uniform-PC unit.
//  Tracks per-thread NZP flags and an active-thread mask, and owns a reconvergence stack.
//  Divergent BRnzp branches split the block into taken and not-taken paths; SSY/SYNC
//  instructions reconverge the paths. Sits in the core beside the decoder and scheduler,
//  and drives the fetch PC.
// PARAMETERS
//  THREADS_PER_BLOCK      4   threads sharing one PC (mask width T)
//  PROGRAM_MEM_ADDR_BITS  8   PC width A
//  DATA_MEM_DATA_BITS     16  per-thread alu_out width (Q1.15); NZP taken from bits [2:0]
//  STACK_DEPTH            4   reconvergence stack entries; each entry is {pc[A], mask[T]}
// PORTS
//  clk                       in   1       clock
//  reset_n                   in   1       asynchronous, active-low reset
//  start                     in   1       launch pulse: load PC 0, mask = thread_enable, clear stack
//  thread_enable             in   T       threads present in this block
//  core_state                in   3       EXECUTE=3'b101, UPDATE=3'b110
//  decoded_pc_mux            in   1       BRnzp instruction
//  decoded_nzp               in   3       branch condition mask
//  decoded_nzp_write_enable  in   1       CMP result write
//  decoded_ssy               in   1       push reconvergence point
//  decoded_sync              in   1       pop stack
//  instruction               in   16      imm9 = instruction[8:0], signed
//  alu_out                   in   T*16    thread i occupies slice [i*16 +: 16]
//  next_pc                   out  A       PC for the next fetch
//  active_mask               out  T       threads executing the current path
//  stack_depth               out  clog2(STACK_DEPTH+1)  valid entries
//  stack_overflow            out  1       sticky; cleared by reset or start
//  stack_underflow           out  1       sticky; cleared by reset or start
// BEHAVIOUR
//  - Reset (async, reset_n=0): next_pc=0, active_mask=0, stack_depth=0, both flags=0, all NZP=0.
//  - Priority: reset > start > core_state actions. start clears NZP, stack and flags.
//  - Target: tgt = PC+1+sext(imm9), computed in A+1 bits signed, then truncated to A bits.
//    PC+1 also wraps mod 2^A.
//  - All updates are registered, one clock after the qualifying state. No action in other states.
//    No action when active_mask==0.
//  - EXECUTE, decoded_pc_mux=1: taken[i] = active[i] & |(nzp[i] & decoded_nzp).
//    - taken==active: next_pc=tgt, mask unchanged.
//    - taken==0: next_pc=PC+1, mask unchanged.
//    - Otherwise the branch diverges. Push {PC+1, active&~taken}, then next_pc=tgt and
//      active_mask=taken.
//  - EXECUTE, decoded_ssy=1: push {tgt, active_mask}; next_pc=PC+1.
//  - EXECUTE, decoded_sync=1, depth>0: pop; next_pc=entry.pc, active_mask=entry.mask.
//  - EXECUTE, decoded_sync=1, depth==0: next_pc=PC+1, stack_underflow<=1.
//  - EXECUTE, other instructions: next_pc=PC+1.
//  - Push when depth==STACK_DEPTH: entry is dropped and stack_overflow<=1.
//    - Divergent branch: still moves to tgt with mask=taken; the not-taken threads are lost.
//    - SSY: behaves as PC+1.
//  - At most one of pc_mux/ssy/sync is expected. If several are set, priority is sync > ssy > pc_mux.
//  - UPDATE with decoded_nzp_write_enable: nzp[i] <= alu_out[i*16 +: 3] for active threads only.
//    Inactive threads keep their NZP.
//  - PC is internal. next_pc is the registered PC; current PC == next_pc.
// TESTING
//  1 Uniform: T=4, mask 1111, all nzp=100, PC=20, BRn imm9=-5 -> next_pc=16, mask 1111.
//    The same with BRp -> next_pc=21.
//  2 Diverge/reconverge: PC=10, SSY imm9=+5 -> depth 1, next_pc 11.
//    At 11, BRn imm9=+2 with nzp n on threads 0,1 only -> next_pc 14, mask 0011, depth 2.
//    At 14, SYNC -> next_pc 12, mask 1100, depth 1.
//    Next SYNC -> next_pc 16, mask 1111, depth 0.
//  3 Overflow: STACK_DEPTH=4, issue 5 SSY -> depth stays 4, stack_overflow=1.
//    start -> flag clears, depth 0.
//  4 Underflow: SYNC at depth 0, PC=7 -> next_pc 8, stack_underflow=1.
//  5 Masked NZP: mask 0101, CMP writes alu_out[2:0]=001 for all threads -> only threads 0,2
//    update; threads 1,3 keep their prior NZP. Check with a subsequent BRp split.
//  6 Wrap/reset: PC=255, BR imm9=+3 -> next_pc 3.
//    Assert reset_n low mid-divergence -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/simt_pc_stack.sv
// simt_pc_stack: per-block PC with active-thread mask, per-thread NZP flags and a reconvergence stack
module simt_pc_stack #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int DATA_MEM_DATA_BITS    = 16,
    parameter int STACK_DEPTH           = 4
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic                                           start,
    input  logic [THREADS_PER_BLOCK-1:0]                   thread_enable,
    input  logic [2:0]                                     core_state,
    input  logic                                           decoded_pc_mux,
    input  logic [2:0]                                     decoded_nzp,
    input  logic                                           decoded_nzp_write_enable,
    input  logic                                           decoded_ssy,
    input  logic                                           decoded_sync,
    input  logic [15:0]                                    instruction,
    input  logic [THREADS_PER_BLOCK*DATA_MEM_DATA_BITS-1:0] alu_out,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]               next_pc,
    output logic [THREADS_PER_BLOCK-1:0]                   active_mask,
    output logic [$clog2(STACK_DEPTH+1)-1:0]               stack_depth,
    output logic                                           stack_overflow,
    output logic                                           stack_underflow
);
    localparam int T  = THREADS_PER_BLOCK;
    localparam int A  = PROGRAM_MEM_ADDR_BITS;
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0] EXECUTE = 3'b101;
    localparam logic [2:0] UPDATE  = 3'b110;

    logic [A-1:0]  pc;
    logic [T-1:0]  mask;
    logic [2:0]    nzp [T];
    logic [A-1:0]  stk_pc [STACK_DEPTH];
    logic [T-1:0]  stk_mask [STACK_DEPTH];
    logic [DW-1:0] depth;
    logic          ovf;
    logic          unf;
    logic [A-1:0]  pc_inc;
    logic [A-1:0]  tgt;
    logic [T-1:0]  taken;
    logic          full;
    logic          empty;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] pop_idx;
    logic          unused_bits;

    assign full        = depth == DW'(STACK_DEPTH);
    assign empty       = depth == '0;
    assign push_idx    = IW'(depth);
    assign pop_idx     = IW'(depth - DW'(1));
    assign unused_bits = ^{alu_out, instruction[15:9]};

    assign next_pc         = pc;
    assign active_mask     = mask;
    assign stack_depth     = depth;
    assign stack_overflow  = ovf;
    assign stack_underflow = unf;

    // Sequential and branch targets (wrap mod 2^A) plus which active threads satisfy the branch condition
    always_comb begin
        pc_inc = pc + A'(1);
        tgt    = A'(32'(pc) + 32'd1 + 32'(signed'(instruction[8:0])));
        taken  = '0;
        for (int i = 0; i < T; i++)
            taken[i] = mask[i] & |(nzp[i] & decoded_nzp);
    end

    // PC, mask, NZP and stack update; sync beats ssy beats branch, nothing happens with an empty mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc    <= '0;
            mask  <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            for (int i = 0; i < T; i++)
                nzp[i] <= '0;
            for (int s = 0; s < STACK_DEPTH; s++) begin
                stk_pc[s]   <= '0;
                stk_mask[s] <= '0;
            end
        end else if (start) begin
            pc    <= '0;
            mask  <= thread_enable;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            for (int i = 0; i < T; i++)
                nzp[i] <= '0;
        end else if (mask != '0 && core_state == EXECUTE) begin
            if (decoded_sync) begin
                if (empty) begin
                    pc  <= pc_inc;
                    unf <= 1'b1;
                end else begin
                    pc    <= stk_pc[pop_idx];
                    mask  <= stk_mask[pop_idx];
                    depth <= depth - DW'(1);
                end
            end else if (decoded_ssy) begin
                pc <= pc_inc;
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    stk_pc[push_idx]   <= tgt;
                    stk_mask[push_idx] <= mask;
                    depth              <= depth + DW'(1);
                end
            end else if (decoded_pc_mux && taken == mask) begin
                pc <= tgt;
            end else if (decoded_pc_mux && taken != '0) begin
                pc   <= tgt;
                mask <= taken;
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    stk_pc[push_idx]   <= pc_inc;
                    stk_mask[push_idx] <= mask & ~taken;
                    depth              <= depth + DW'(1);
                end
            end else begin
                pc <= pc_inc;
            end
        end else if (mask != '0 && core_state == UPDATE && decoded_nzp_write_enable) begin
            for (int i = 0; i < T; i++)
                if (mask[i])
                    nzp[i] <= alu_out[i*DATA_MEM_DATA_BITS +: 3];
        end
    end
endmodule
